// File: rtl/e203_exu_pkg.sv
// Shared execution-unit types and helpers: OITF entry payload and
// pointer/wrap-flag increment.
package e203_exu_pkg;

  localparam int unsigned OITF_DEPTH_DFLT = 2;
  localparam int unsigned RFIDX_WIDTH     = 5;
  localparam int unsigned PC_SIZE         = 32;

  typedef struct packed {
    logic                   rdwen;
    logic                   rdfpu;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic [PC_SIZE-1:0]     pc;
  } oitf_entry_t;

  // Returns {next_flg, next_ptr}; the flag toggles when the pointer wraps to 0.
  function automatic logic [32:0] ptr_inc(input logic [31:0] ptr,
                                          input logic        flg,
                                          input int unsigned depth);
    logic [32:0] nxt;
    if (ptr == 32'(depth - 1)) begin
      nxt = {~flg, 32'd0};
    end else begin
      nxt = {flg, ptr + 32'd1};
    end
    return nxt;
  endfunction

  // True when a pending entry writes the register named by a dispatch operand.
  function automatic logic rd_hit(input oitf_entry_t            ent,
                                  input logic                   en,
                                  input logic [RFIDX_WIDTH-1:0] idx,
                                  input logic                   fpu);
    return en & ent.rdwen & (ent.rdidx == idx) & (ent.rdfpu == fpu);
  endfunction

endpackage

// File: rtl/e203_exu_oitf_ptr.sv
// Circular-buffer pointer with wrap flag; advances by one when enabled.
module e203_exu_oitf_ptr
  import e203_exu_pkg::*;
#(
  parameter int unsigned DEPTH = OITF_DEPTH_DFLT,
  parameter int unsigned W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  output logic [W-1:0] ptr,
  output logic         flg
);

  logic [32:0] nxt_c;

  assign nxt_c = ptr_inc(32'(ptr), flg, DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      flg <= 1'b0;
    end else if (ena) begin
      ptr <= W'(nxt_c[31:0]);
      flg <= nxt_c[32];
    end
  end

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-pipe ops, feeds
// the oldest one to write-back and flags RAW/WAW hazards to dispatch.
module e203_exu_oitf_trk
  import e203_exu_pkg::*;
#(
  parameter int unsigned DEPTH   = OITF_DEPTH_DFLT,
  parameter int unsigned ITAG_W  = $clog2(DEPTH),
  parameter int unsigned RFIDX_W = RFIDX_WIDTH,
  parameter int unsigned PC_W    = PC_SIZE
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               dis_ena,
  output logic               dis_ready,
  output logic [ITAG_W-1:0]  dis_ptr,

  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic               disp_i_rdfpu,
  input  logic [PC_W-1:0]    disp_i_pc,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rs3en,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rs3idx,
  input  logic               disp_i_rs1fpu,
  input  logic               disp_i_rs2fpu,
  input  logic               disp_i_rs3fpu,

  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprs3,
  output logic               oitfrd_match_disprd,

  input  logic               oitf_ret_ena,
  output logic [ITAG_W-1:0]  oitf_ret_ptr,
  output logic [RFIDX_W-1:0] oitf_ret_rdidx,
  output logic [PC_W-1:0]    oitf_ret_pc,
  output logic               oitf_ret_rdwen,
  output logic               oitf_ret_rdfpu,
  output logic               oitf_empty
);

  logic [ITAG_W-1:0] alc_ptr;
  logic [ITAG_W-1:0] ret_ptr;
  logic              alc_flg;
  logic              ret_flg;
  logic              ptr_eq;
  logic              full;
  logic              empty;
  logic              alc_ena;
  logic              ret_ena;

  oitf_entry_t       ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  oitf_entry_t       dis_ent;
  oitf_entry_t       ret_ent;

  e203_exu_oitf_ptr #(
    .DEPTH (DEPTH),
    .W     (ITAG_W)
  ) u_alc_ptr (
    .clk (clk),
    .rst (rst),
    .ena (alc_ena),
    .ptr (alc_ptr),
    .flg (alc_flg)
  );

  e203_exu_oitf_ptr #(
    .DEPTH (DEPTH),
    .W     (ITAG_W)
  ) u_ret_ptr (
    .clk (clk),
    .rst (rst),
    .ena (ret_ena),
    .ptr (ret_ptr),
    .flg (ret_flg)
  );

  // Equal pointers mean empty or full; the wrap flags tell which.
  assign ptr_eq    = (alc_ptr == ret_ptr);
  assign empty     = ptr_eq & (alc_flg == ret_flg);
  assign full      = ptr_eq & (alc_flg != ret_flg);
  assign alc_ena   = dis_ena & ~full;
  assign ret_ena   = oitf_ret_ena & ~empty;

  assign dis_ready  = ~full;
  assign dis_ptr    = alc_ptr;
  assign oitf_empty = empty;

  assign dis_ent.rdwen = disp_i_rdwen;
  assign dis_ent.rdfpu = disp_i_rdfpu;
  assign dis_ent.rdidx = RFIDX_WIDTH'(disp_i_rdidx);
  assign dis_ent.pc    = PC_SIZE'(disp_i_pc);

  // Entry storage; alloc and retire never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      if (alc_ena) begin
        vld_q[alc_ptr] <= 1'b1;
        ent_q[alc_ptr] <= dis_ent;
      end
      if (ret_ena) begin
        vld_q[ret_ptr] <= 1'b0;
      end
    end
  end

  assign ret_ent        = ent_q[ret_ptr];
  assign oitf_ret_ptr   = ret_ptr;
  assign oitf_ret_rdidx = RFIDX_W'(ret_ent.rdidx);
  assign oitf_ret_pc    = PC_W'(ret_ent.pc);
  assign oitf_ret_rdwen = ret_ent.rdwen;
  assign oitf_ret_rdfpu = ret_ent.rdfpu;

  // Hazard flags include an entry that is retiring this very cycle.
  always_comb begin
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprs3 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        oitfrd_match_disprs1 |= rd_hit(ent_q[i], disp_i_rs1en,
                                       RFIDX_WIDTH'(disp_i_rs1idx), disp_i_rs1fpu);
        oitfrd_match_disprs2 |= rd_hit(ent_q[i], disp_i_rs2en,
                                       RFIDX_WIDTH'(disp_i_rs2idx), disp_i_rs2fpu);
        oitfrd_match_disprs3 |= rd_hit(ent_q[i], disp_i_rs3en,
                                       RFIDX_WIDTH'(disp_i_rs3idx), disp_i_rs3fpu);
        oitfrd_match_disprd  |= rd_hit(ent_q[i], disp_i_rdwen,
                                       RFIDX_WIDTH'(disp_i_rdidx), disp_i_rdfpu);
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Bench for e203_exu_oitf_trk: directed scenarios plus randomized traffic
// checked against a queue-based model of the in-flight ops.
module tb_e203_exu_oitf_trk;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ITAG_W = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              dis_ena;
  logic              dis_ready;
  logic [ITAG_W-1:0] dis_ptr;
  logic              disp_i_rdwen;
  logic [4:0]        disp_i_rdidx;
  logic              disp_i_rdfpu;
  logic [31:0]       disp_i_pc;
  logic              disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
  logic [4:0]        disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx;
  logic              disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
  logic              oitfrd_match_disprs1, oitfrd_match_disprs2;
  logic              oitfrd_match_disprs3, oitfrd_match_disprd;
  logic              oitf_ret_ena;
  logic [ITAG_W-1:0] oitf_ret_ptr;
  logic [4:0]        oitf_ret_rdidx;
  logic [31:0]       oitf_ret_pc;
  logic              oitf_ret_rdwen;
  logic              oitf_ret_rdfpu;
  logic              oitf_empty;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          itag;
    logic        rdwen;
    logic        rdfpu;
    logic [4:0]  rdidx;
    logic [31:0] pc;
  } ment_t;

  ment_t mq[$];
  int    m_alc = 0;
  int    m_ret = 0;

  always #5 clk = ~clk;

  e203_exu_oitf_trk #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .dis_ena              (dis_ena),
    .dis_ready            (dis_ready),
    .dis_ptr              (dis_ptr),
    .disp_i_rdwen         (disp_i_rdwen),
    .disp_i_rdidx         (disp_i_rdidx),
    .disp_i_rdfpu         (disp_i_rdfpu),
    .disp_i_pc            (disp_i_pc),
    .disp_i_rs1en         (disp_i_rs1en),
    .disp_i_rs2en         (disp_i_rs2en),
    .disp_i_rs3en         (disp_i_rs3en),
    .disp_i_rs1idx        (disp_i_rs1idx),
    .disp_i_rs2idx        (disp_i_rs2idx),
    .disp_i_rs3idx        (disp_i_rs3idx),
    .disp_i_rs1fpu        (disp_i_rs1fpu),
    .disp_i_rs2fpu        (disp_i_rs2fpu),
    .disp_i_rs3fpu        (disp_i_rs3fpu),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprs3 (oitfrd_match_disprs3),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .oitf_ret_ena         (oitf_ret_ena),
    .oitf_ret_ptr         (oitf_ret_ptr),
    .oitf_ret_rdidx       (oitf_ret_rdidx),
    .oitf_ret_pc          (oitf_ret_pc),
    .oitf_ret_rdwen       (oitf_ret_rdwen),
    .oitf_ret_rdfpu       (oitf_ret_rdfpu),
    .oitf_empty           (oitf_empty)
  );

  // Any pending op that writes this register makes the operand hazardous.
  function automatic logic exp_match(input logic en, input logic [4:0] idx, input logic fpu);
    foreach (mq[i]) begin
      if (en && mq[i].rdwen && mq[i].rdidx == idx && mq[i].rdfpu == fpu) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_payload(input logic wen, input logic [4:0] idx, input logic fpu,
                             input logic [31:0] pc);
    disp_i_rdwen = wen;
    disp_i_rdidx = idx;
    disp_i_rdfpu = fpu;
    disp_i_pc    = pc;
  endtask

  task automatic set_srcs(input logic e1, input logic [4:0] i1, input logic f1,
                          input logic e2, input logic [4:0] i2, input logic f2,
                          input logic e3, input logic [4:0] i3, input logic f3);
    disp_i_rs1en = e1; disp_i_rs1idx = i1; disp_i_rs1fpu = f1;
    disp_i_rs2en = e2; disp_i_rs2idx = i2; disp_i_rs2fpu = f2;
    disp_i_rs3en = e3; disp_i_rs3idx = i3; disp_i_rs3fpu = f3;
  endtask

  // One clock with the given requests; the model follows the FIFO rules.
  task automatic cyc(input logic de, input logic re);
    bit    do_alc, do_ret;
    ment_t e;
    dis_ena      = de;
    oitf_ret_ena = re;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_alc = 0;
      m_ret = 0;
    end else begin
      do_alc = de && (mq.size() < DEPTH);
      do_ret = re && (mq.size() > 0);
      if (do_ret) begin
        void'(mq.pop_front());
        m_ret = (m_ret + 1) % DEPTH;
      end
      if (do_alc) begin
        e.itag  = m_alc;
        e.rdwen = disp_i_rdwen;
        e.rdfpu = disp_i_rdfpu;
        e.rdidx = disp_i_rdidx;
        e.pc    = disp_i_pc;
        mq.push_back(e);
        m_alc = (m_alc + 1) % DEPTH;
      end
    end
    #1;
    dis_ena      = 1'b0;
    oitf_ret_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    set_srcs(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    set_payload(1'b1, 5'd0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (oitf_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", oitf_empty); end
    n_cmp++; if (dis_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", dis_ready); end
    n_cmp++; if (dis_ptr !== 1'b0) begin n_err++; $display("FAIL rst_dis_ptr got=%0d exp=0", dis_ptr); end
    n_cmp++; if (oitf_ret_ptr !== 1'b0) begin n_err++; $display("FAIL rst_ret_ptr got=%0d exp=0", oitf_ret_ptr); end
    n_cmp++; if ({oitf_ret_rdidx, oitf_ret_pc, oitf_ret_rdwen, oitf_ret_rdfpu} !== 39'd0) begin
      n_err++; $display("FAIL rst_ret_payload got idx=%0d pc=%h exp 0", oitf_ret_rdidx, oitf_ret_pc); end
    n_cmp++; if ({oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd} !== 4'b0) begin
      n_err++; $display("FAIL rst_match got=%b%b%b%b exp=0000", oitfrd_match_disprs1,
                        oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd); end
    set_srcs(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_payload(1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic test_fill();
    set_payload(1'b1, 5'd5, 1'b0, 32'h8000_0010);
    #1;
    n_cmp++; if (dis_ptr !== 1'b0) begin n_err++; $display("FAIL fill_ptr0 got=%0d exp=0", dis_ptr); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (dis_ptr !== 1'b1) begin n_err++; $display("FAIL fill_ptr1 got=%0d exp=1", dis_ptr); end
    n_cmp++; if (dis_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready1 got=%b exp=1", dis_ready); end
    set_payload(1'b1, 5'd6, 1'b0, 32'h8000_0014);
    cyc(1'b1, 1'b0);
    n_cmp++; if (dis_ready !== 1'b0) begin n_err++; $display("FAIL fill_full got=%b exp=0", dis_ready); end
    n_cmp++; if (oitf_ret_ptr !== 1'b0) begin n_err++; $display("FAIL fill_ret_ptr got=%0d exp=0", oitf_ret_ptr); end
    n_cmp++; if (oitf_ret_rdidx !== 5'd5) begin n_err++; $display("FAIL fill_ret_rdidx got=%0d exp=5", oitf_ret_rdidx); end
    n_cmp++; if (oitf_ret_pc !== 32'h8000_0010) begin n_err++; $display("FAIL fill_ret_pc got=%h exp=80000010", oitf_ret_pc); end
    // Dispatch while full must be dropped.
    set_payload(1'b1, 5'd7, 1'b1, 32'hdead_beef);
    cyc(1'b1, 1'b0);
    n_cmp++; if (dis_ready !== 1'b0 || dis_ptr !== 1'b0 || oitf_empty !== 1'b0) begin
      n_err++; $display("FAIL full_ignore got ready=%b ptr=%0d empty=%b exp 0/0/0", dis_ready, dis_ptr, oitf_empty); end
    n_cmp++; if (oitf_ret_rdidx !== 5'd5 || oitf_ret_pc !== 32'h8000_0010) begin
      n_err++; $display("FAIL full_ignore_payload got idx=%0d pc=%h exp 5/80000010", oitf_ret_rdidx, oitf_ret_pc); end
  endtask

  task automatic test_deps();
    set_payload(1'b0, 5'd0, 1'b0, 32'h0);
    set_srcs(1'b1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b0);
    #1;
    n_cmp++; if (oitfrd_match_disprs1 !== 1'b1) begin n_err++; $display("FAIL dep_rs1_int got=%b exp=1", oitfrd_match_disprs1); end
    n_cmp++; if (oitfrd_match_disprs2 !== 1'b0) begin n_err++; $display("FAIL dep_rs2_off got=%b exp=0", oitfrd_match_disprs2); end
    n_cmp++; if (oitfrd_match_disprs3 !== 1'b1) begin n_err++; $display("FAIL dep_rs3_x6 got=%b exp=1", oitfrd_match_disprs3); end
    n_cmp++; if (oitfrd_match_disprd !== 1'b0) begin n_err++; $display("FAIL dep_rd_off got=%b exp=0", oitfrd_match_disprd); end
    disp_i_rs1fpu = 1'b1;
    disp_i_rs3idx = 5'd7;
    #1;
    n_cmp++; if (oitfrd_match_disprs1 !== 1'b0) begin n_err++; $display("FAIL dep_rs1_fpu got=%b exp=0", oitfrd_match_disprs1); end
    n_cmp++; if (oitfrd_match_disprs3 !== 1'b0) begin n_err++; $display("FAIL dep_rs3_x7 got=%b exp=0", oitfrd_match_disprs3); end
    set_payload(1'b1, 5'd5, 1'b0, 32'h0);
    #1;
    n_cmp++; if (oitfrd_match_disprd !== 1'b1) begin n_err++; $display("FAIL dep_rd_waw got=%b exp=1", oitfrd_match_disprd); end
    set_srcs(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_full_simul();
    // FIFO is full with x5 (itag 0) and x6 (itag 1).
    set_payload(1'b1, 5'd9, 1'b1, 32'h8000_0020);
    cyc(1'b1, 1'b1);
    n_cmp++; if (oitf_ret_ptr !== 1'b1) begin n_err++; $display("FAIL simul_ret_ptr got=%0d exp=1", oitf_ret_ptr); end
    n_cmp++; if (dis_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready got=%b exp=1", dis_ready); end
    n_cmp++; if (dis_ptr !== 1'b0) begin n_err++; $display("FAIL simul_dis_ptr got=%0d exp=0", dis_ptr); end
    n_cmp++; if (oitf_ret_rdidx !== 5'd6) begin n_err++; $display("FAIL simul_ret_rdidx got=%0d exp=6", oitf_ret_rdidx); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (dis_ready !== 1'b0 || dis_ptr !== 1'b1) begin
      n_err++; $display("FAIL wrap_alloc got ready=%b ptr=%0d exp 0/1", dis_ready, dis_ptr); end
    cyc(1'b0, 1'b1);
    n_cmp++; if (oitf_ret_ptr !== 1'b0 || oitf_ret_rdidx !== 5'd9 || oitf_ret_pc !== 32'h8000_0020 || oitf_ret_rdfpu !== 1'b1) begin
      n_err++; $display("FAIL wrap_payload got ptr=%0d idx=%0d pc=%h fpu=%b exp 0/9/80000020/1",
                        oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_pc, oitf_ret_rdfpu); end
    cyc(1'b0, 1'b1);
    n_cmp++; if (oitf_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", oitf_empty); end
    // Retire while empty is ignored; alloc+retire while empty only allocates.
    cyc(1'b0, 1'b1);
    n_cmp++; if (oitf_empty !== 1'b1 || oitf_ret_ptr !== 1'b1) begin
      n_err++; $display("FAIL empty_ret got empty=%b ptr=%0d exp 1/1", oitf_empty, oitf_ret_ptr); end
    set_payload(1'b1, 5'd3, 1'b0, 32'h8000_0030);
    cyc(1'b1, 1'b1);
    n_cmp++; if (oitf_empty !== 1'b0 || oitf_ret_rdidx !== 5'd3 || dis_ptr !== 1'b0) begin
      n_err++; $display("FAIL empty_simul got empty=%b idx=%0d dptr=%0d exp 0/3/0", oitf_empty, oitf_ret_rdidx, dis_ptr); end
    cyc(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_payload(1'b1, 5'd12, 1'b0, 32'h8000_0100);
    cyc(1'b1, 1'b0);
    set_payload(1'b1, 5'd13, 1'b0, 32'h8000_0104);
    cyc(1'b1, 1'b0);
    set_srcs(1'b1, 5'd12, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 5'd0, 1'b0);
    set_payload(1'b1, 5'd13, 1'b0, 32'h0);
    #1;
    n_cmp++; if (oitfrd_match_disprs1 !== 1'b1 || oitfrd_match_disprd !== 1'b1) begin
      n_err++; $display("FAIL pre_rst_match got rs1=%b rd=%b exp 1/1", oitfrd_match_disprs1, oitfrd_match_disprd); end
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_empty got empty=%b ready=%b exp 1/1", oitf_empty, dis_ready); end
    n_cmp++; if (dis_ptr !== 1'b0 || oitf_ret_ptr !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ptrs got dis=%0d ret=%0d exp 0/0", dis_ptr, oitf_ret_ptr); end
    n_cmp++; if ({oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd} !== 4'b0) begin
      n_err++; $display("FAIL mid_rst_match got=%b%b%b%b exp=0000", oitfrd_match_disprs1,
                        oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd); end
    n_cmp++; if (oitf_ret_pc !== 32'h0 || oitf_ret_rdidx !== 5'd0) begin
      n_err++; $display("FAIL mid_rst_payload got idx=%0d pc=%h exp 0/0", oitf_ret_rdidx, oitf_ret_pc); end
    set_srcs(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Ten ops, each allocated in the same cycle its predecessor retires.
  task automatic test_back_to_back();
    logic [4:0]  idx [10];
    logic [31:0] pc  [10];
    logic        wen [10];
    for (int i = 0; i < 10; i++) begin
      idx[i] = 5'($urandom_range(1, 31));
      pc[i]  = 32'h8000_0000 + 32'(i * 4);
      wen[i] = 1'($urandom);
    end
    set_payload(wen[0], idx[0], 1'b0, pc[0]);
    cyc(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i < 10) set_payload(wen[i], idx[i], 1'b0, pc[i]);
      #1;
      n_cmp++; if (oitf_ret_ptr !== ITAG_W'((i - 1) % 2) || oitf_ret_rdidx !== idx[i-1] ||
                   oitf_ret_pc !== pc[i-1] || oitf_ret_rdwen !== wen[i-1]) begin
        n_err++; $display("FAIL b2b_op%0d got ptr=%0d idx=%0d pc=%h wen=%b exp %0d/%0d/%h/%b", i - 1,
                          oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_pc, oitf_ret_rdwen,
                          (i - 1) % 2, idx[i-1], pc[i-1], wen[i-1]); end
      cyc(i < 10, 1'b1);
    end
    n_cmp++; if (oitf_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", oitf_empty); end
  endtask

  task automatic test_random();
    logic de, re;
    for (int c = 0; c < 400; c++) begin
      de = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      set_payload(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), $urandom);
      set_srcs(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
               1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
               1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
      #1;
      n_cmp++; if (dis_ready !== (mq.size() < DEPTH) || oitf_empty !== (mq.size() == 0)) begin
        n_err++; $display("FAIL rnd_flags c=%0d got ready=%b empty=%b occ=%0d", c, dis_ready, oitf_empty, mq.size()); end
      n_cmp++; if (dis_ptr !== ITAG_W'(m_alc) || oitf_ret_ptr !== ITAG_W'(m_ret)) begin
        n_err++; $display("FAIL rnd_ptrs c=%0d got dis=%0d ret=%0d exp %0d/%0d", c, dis_ptr, oitf_ret_ptr, m_alc, m_ret); end
      if (mq.size() > 0) begin
        n_cmp++; if (oitf_ret_ptr !== ITAG_W'(mq[0].itag) || oitf_ret_rdidx !== mq[0].rdidx ||
                     oitf_ret_pc !== mq[0].pc || oitf_ret_rdwen !== mq[0].rdwen || oitf_ret_rdfpu !== mq[0].rdfpu) begin
          n_err++; $display("FAIL rnd_ret c=%0d got idx=%0d pc=%h exp idx=%0d pc=%h", c,
                            oitf_ret_rdidx, oitf_ret_pc, mq[0].rdidx, mq[0].pc); end
      end
      n_cmp++; if (oitfrd_match_disprs1 !== exp_match(disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu) ||
                   oitfrd_match_disprs2 !== exp_match(disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu) ||
                   oitfrd_match_disprs3 !== exp_match(disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu) ||
                   oitfrd_match_disprd  !== exp_match(disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu)) begin
        n_err++; $display("FAIL rnd_match c=%0d got=%b%b%b%b exp=%b%b%b%b", c,
                          oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
                          exp_match(disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu),
                          exp_match(disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu),
                          exp_match(disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu),
                          exp_match(disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu)); end
      cyc(de, re);
    end
  endtask

  initial begin
    rst          = 1'b1;
    dis_ena      = 1'b0;
    oitf_ret_ena = 1'b0;
    set_payload(1'b0, 5'd0, 1'b0, 32'h0);
    set_srcs(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_fill();
    test_deps();
    test_full_simul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
